atm_core_arbiter: RTL and testbench
===================================

# atm_core_arbiter

Round-robin arbiter that shares a single ATM core between `N_TERM` customer terminals. It captures a granted terminal's transaction fields and drives them into the core for a fixed number of cycles. It then returns the core's balance and success flag to that terminal and pulses the core's active-low reset so the next session re-authenticates from the core's idle state. It sits between the terminal front-ends and the ATM core, and is the only driver of the core's input ports.

## Interface
- `N_TERM`, default 4: number of terminals; must be ≥2.
- `CORE_LAT`, default 4: cycles each transaction is held on the core before results are sampled; must be ≥1.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-low.
- `req` input, N_TERM: per-terminal request, level; must be held until `done` of that terminal.
- `t_operation` input, 3·N_TERM: per-terminal opcode (3 = show balance, 5 = deposit).
- `t_acc_num` input, 4·N_TERM: per-terminal account number.
- `t_pin` input, 16·N_TERM: per-terminal PIN.
- `t_new_pin` input, 16·N_TERM: per-terminal new PIN.
- `t_amount` input, 32·N_TERM: per-terminal amount.
- `t_language` input, N_TERM: per-terminal language select.
- `grant` output, N_TERM: one-hot, high for the owner during RUN and RESP.
- `done` output, N_TERM: one-hot single-cycle pulse; results are valid while it is high.
- `aborted` output, N_TERM: one-hot single-cycle pulse when the owner drops `req` in RUN.
- `result_balance` output, 32: balance sampled from the core.
- `result_success` output, 1: success flag sampled from the core.
- `core_rst` output, 1: core reset, active-low.
- `core_operation`, `core_acc_num`, `core_pin`, `core_new_pin`, `core_amount`, `core_language` outputs, 3/4/16/16/32/1: core transaction inputs.
- `core_balance` input, 32, from core.
- `core_success` input, 1, from core.
- `core_state` input, 3, from core; used only for debug visibility and not for sequencing.

## Operation
- FSM states:
  - IDLE: wait for any `req`.
  - RUN: core driven; `cnt` counts down from CORE_LAT−1.
  - RESP: results latched, `done` pulsed.
  - CLEAR: `core_rst`=0 for one cycle.
- IDLE, when any `req` is set:
  - Winner = first set bit of `req` scanning from `ptr` upward, with wrap N_TERM−1→0.
  - On that edge: `sel`←winner; all six winner fields captured into holding registers; `cnt`←CORE_LAT−1; go to RUN.
- RUN:
  - `core_*` are driven from the holding registers; later changes on `t_*` are ignored.
  - If `req[sel]`=0: go to CLEAR, pulse `aborted[sel]`, no `done`, `ptr` unchanged.
  - Else if `cnt`=0: go to RESP, latching `result_balance`←`core_balance` and `result_success`←`core_success`.
  - Else `cnt`−1.
- RESP: `done[sel]`=1 for exactly one cycle; `ptr`←(sel+1) mod N_TERM; go to CLEAR.
- CLEAR: `core_rst`=0, `grant`=0; go to IDLE.
- Outside RUN, `core_*` outputs hold their last captured values.
- `result_*` hold their value until the next RESP.
- Under reset, all outputs are 0; FSM=IDLE, `ptr`=0, `cnt`=0.
  - `core_rst`=0 during reset and 1 from the first edge after release, except in CLEAR.
- Reset asserted mid-session: immediate return to the reset values; no `done` or `aborted` for the interrupted session.

## Timing
- `req` seen at edge k in IDLE → `grant` high from k+1.
- `done` high in cycle k+1+CORE_LAT.
- `core_rst` low in cycle k+2+CORE_LAT; next grant possible at k+4+CORE_LAT.
- Slot length per session = CORE_LAT+3 cycles including IDLE.
- All outputs are registered; no combinational path from `req` or `t_*` to any output.
- Simultaneous requests are served strictly in round-robin order; no terminal waits more than N_TERM−1 sessions.
- `req` toggling in IDLE/RESP/CLEAR has no effect other than on winner selection in IDLE.

## Structure
- Shared package `atm_pkg` holds:
  - opcode constants: OP_BALANCE=3, OP_DEPOSIT=5;
  - field widths (OP_W=3, ACC_W=4, PIN_W=16, AMT_W=32);
  - arbiter state enum {IDLE, RUN, RESP, CLEAR}.
- Sub-module `rr_picker`: combinational N_TERM round-robin priority select from (`req`, `ptr`) giving a one-hot winner and its index.

## Test plan
- Reset test: hold `rst`=0 → all outputs 0, `core_rst`=0; release → `core_rst`=1 next edge, `grant`=0.
- Single request: term0 sends op3, acc1, PIN 1234 (CORE_LAT=4).
  - `grant[0]` rises 1 cycle later.
  - `done[0]` rises 5 cycles after the request edge with `result_balance`=1000 and `result_success`=1.
  - `core_rst` is low in the following cycle.
- Deposit: term1 sends op5, acc1, amount 1000 after the previous session → `done[1]` with `result_balance`=2000.
- Fairness: `req`=4'b1111 held continuously from reset → `done` order 0,1,2,3,0; each `done` spaced 7 cycles apart.
- Abort: term2 drops `req` two cycles into RUN → `aborted[2]` pulse, no `done[2]`, CLEAR next cycle, `ptr` still 2.
  - Re-raising `req[2]` gets the next grant.
- Reset mid-RUN: assert `rst` during RUN → no `done`, FSM IDLE, `ptr`=0.
  - Term3 then requests and is granted normally.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared ATM transaction field widths, opcodes and arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package atm_pkg;

    localparam int OP_W  = 3;
    localparam int ACC_W = 4;
    localparam int PIN_W = 16;
    localparam int AMT_W = 32;

    localparam logic [OP_W-1:0] OP_BALANCE = 3'd3;
    localparam logic [OP_W-1:0] OP_DEPOSIT = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/atm_core_arbiter_if.sv
// Terminal-side and core-side signal bundle for the ATM core arbiter.
// Latency: n/a (wiring only).
// Backpressure: level req held by a terminal until its done or abort.
interface atm_core_arbiter_if
    import atm_pkg::*;
#(
    parameter int N_TERM = 4
);
    logic [N_TERM-1:0]       req;
    logic [OP_W*N_TERM-1:0]  t_operation;
    logic [ACC_W*N_TERM-1:0] t_acc_num;
    logic [PIN_W*N_TERM-1:0] t_pin;
    logic [PIN_W*N_TERM-1:0] t_new_pin;
    logic [AMT_W*N_TERM-1:0] t_amount;
    logic [N_TERM-1:0]       t_language;

    logic [N_TERM-1:0]       grant;
    logic [N_TERM-1:0]       done;
    logic [N_TERM-1:0]       aborted;
    logic [AMT_W-1:0]        result_balance;
    logic                    result_success;

    logic                    core_rst;
    logic [OP_W-1:0]         core_operation;
    logic [ACC_W-1:0]        core_acc_num;
    logic [PIN_W-1:0]        core_pin;
    logic [PIN_W-1:0]        core_new_pin;
    logic [AMT_W-1:0]        core_amount;
    logic                    core_language;
    logic [AMT_W-1:0]        core_balance;
    logic                    core_success;
    logic [2:0]              core_state;

    modport master (
        input  req, t_operation, t_acc_num, t_pin, t_new_pin, t_amount, t_language,
        input  core_balance, core_success, core_state,
        output grant, done, aborted, result_balance, result_success,
        output core_rst, core_operation, core_acc_num, core_pin, core_new_pin,
        output core_amount, core_language
    );

    modport slave (
        output req, t_operation, t_acc_num, t_pin, t_new_pin, t_amount, t_language,
        output core_balance, core_success, core_state,
        input  grant, done, aborted, result_balance, result_success,
        input  core_rst, core_operation, core_acc_num, core_pin, core_new_pin,
        input  core_amount, core_language
    );

endinterface

// File: rtl/atm_core_arbiter_rr_picker.sv
// Round-robin priority select: first set req bit at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; an all-zero req yields an all-zero one-hot.
module rr_picker #(
    parameter int N_TERM = 4,
    parameter int PTR_W  = 2
) (
    input  logic [N_TERM-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [N_TERM-1:0] win_oh,
    output logic [PTR_W-1:0]  win_idx
);
    always_comb begin
        int  idx;
        logic found;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_TERM; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_TERM) idx = idx - N_TERM;
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/atm_core_arbiter.sv
// Shares one ATM core among N_TERM terminals in round-robin sessions.
// Latency: grant 1 cycle after req, done CORE_LAT+1 cycles after req; slot CORE_LAT+3.
// Backpressure: req is a held level; dropping it mid-session aborts the session.
module atm_core_arbiter
    import atm_pkg::*;
#(
    parameter int N_TERM   = 4,
    parameter int CORE_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    atm_core_arbiter_if.master bus
);
    localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CORE_LAT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_TERM - 1);

    arb_state_e        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d, sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_TERM-1:0] grant_q, grant_d, done_q, done_d, aborted_q, aborted_d;
    logic [AMT_W-1:0]  bal_q, bal_d, amt_q, amt_d;
    logic              succ_q, succ_d, core_rst_q, core_rst_d, lang_q, lang_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [PIN_W-1:0]  pin_q, pin_d, npin_q, npin_d;

    logic [N_TERM-1:0] pick_oh;
    logic [PTR_W-1:0]  pick_idx;

    rr_picker #(.N_TERM(N_TERM), .PTR_W(PTR_W)) u_picker (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        done_d     = '0;
        aborted_d  = '0;
        bal_d      = bal_q;
        succ_d     = succ_q;
        op_d       = op_q;
        acc_d      = acc_q;
        pin_d      = pin_q;
        npin_d     = npin_q;
        amt_d      = amt_q;
        lang_d     = lang_q;
        grant_d    = '0;
        core_rst_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (|pick_oh) begin
                    sel_d   = pick_idx;
                    op_d    = bus.t_operation[pick_idx*OP_W +: OP_W];
                    acc_d   = bus.t_acc_num[pick_idx*ACC_W +: ACC_W];
                    pin_d   = bus.t_pin[pick_idx*PIN_W +: PIN_W];
                    npin_d  = bus.t_new_pin[pick_idx*PIN_W +: PIN_W];
                    amt_d   = bus.t_amount[pick_idx*AMT_W +: AMT_W];
                    lang_d  = bus.t_language[pick_idx];
                    cnt_d   = CNT_INIT;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.req[sel_q]) begin
                    aborted_d[sel_q] = 1'b1;
                    state_d          = CLEAR;
                end else if (cnt_q == '0) begin
                    // Results are sampled on the same edge that raises done.
                    bal_d         = bus.core_balance;
                    succ_d        = bus.core_success;
                    done_d[sel_q] = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                ptr_d   = (sel_q == PTR_LAST) ? '0 : sel_q + 1'b1;
                state_d = CLEAR;
            end
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RUN || state_d == RESP) grant_d[sel_d] = 1'b1;
        core_rst_d = (state_d != CLEAR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            aborted_q  <= '0;
            bal_q      <= '0;
            succ_q     <= 1'b0;
            core_rst_q <= 1'b0;
            op_q       <= '0;
            acc_q      <= '0;
            pin_q      <= '0;
            npin_q     <= '0;
            amt_q      <= '0;
            lang_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            bal_q      <= bal_d;
            succ_q     <= succ_d;
            core_rst_q <= core_rst_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            pin_q      <= pin_d;
            npin_q     <= npin_d;
            amt_q      <= amt_d;
            lang_q     <= lang_d;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.result_balance = bal_q;
    assign bus.result_success = succ_q;
    assign bus.core_rst       = core_rst_q;
    assign bus.core_operation = op_q;
    assign bus.core_acc_num   = acc_q;
    assign bus.core_pin       = pin_q;
    assign bus.core_new_pin   = npin_q;
    assign bus.core_amount    = amt_q;
    assign bus.core_language  = lang_q;

endmodule

// File: tb/tb_atm_core_arbiter.sv
// Self-checking bench for atm_core_arbiter with a behavioural single-account ATM core.
// Latency: n/a. Backpressure: n/a.
module tb_atm_core_arbiter;
    import atm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    atm_core_arbiter_if #(.N_TERM(4)) bus();

    atm_core_arbiter #(.N_TERM(4), .CORE_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core model: account 1, PIN 1234, balance 1000; deposits report balance+amount.
    assign bus.core_state = 3'd0;
    always_comb begin
        bus.core_balance = '0;
        bus.core_success = 1'b0;
        if (bus.core_rst && bus.core_acc_num == 4'd1 && bus.core_pin == 16'd1234) begin
            if (bus.core_operation == OP_BALANCE) begin
                bus.core_balance = 32'd1000;
                bus.core_success = 1'b1;
            end else if (bus.core_operation == OP_DEPOSIT) begin
                bus.core_balance = 32'd1000 + bus.core_amount;
                bus.core_success = 1'b1;
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  op;
        logic [3:0]  acc;
        logic [15:0] pin;
        logic [31:0] amt;
        logic [3:0]  exp_oh;
        logic [31:0] exp_bal;
        logic        exp_succ;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_term(input int t, input logic [2:0] op, input logic [3:0] acc,
                            input logic [15:0] pin, input logic [31:0] amt);
        bus.t_operation[t*3 +: 3]  = op;
        bus.t_acc_num[t*4 +: 4]    = acc;
        bus.t_pin[t*16 +: 16]      = pin;
        bus.t_new_pin[t*16 +: 16]  = 16'd0;
        bus.t_amount[t*32 +: 32]   = amt;
        bus.t_language[t]          = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        for (int t = 0; t < 4; t++) set_term(t, v.op, v.acc, v.pin, v.amt);
        bus.req = v.req;
        n = 0;
        do begin tick(); n++; end while (bus.grant == 4'b0 && n < 20);
        chk({tag, ".grant"}, bus.grant, v.exp_oh);
        n = 0;
        while (bus.done == 4'b0 && n < 20) begin tick(); n++; end
        chk({tag, ".done"}, bus.done, v.exp_oh);
        chk({tag, ".bal"}, bus.result_balance, v.exp_bal);
        chk({tag, ".succ"}, bus.result_success, v.exp_succ);
        bus.req = 4'b0;
        tick();
        chk({tag, ".core_rst"}, bus.core_rst, 1'b0);
        chk({tag, ".hold"}, bus.result_balance, v.exp_bal);
        tick();
    endtask

    vec_t vt[6];
    vec_t v_t1, v_t3;
    logic [3:0] exp_ord[5];
    int         done_t[$];
    logic [3:0] done_v[$];

    initial begin
        int n;
        vt[0] = '{4'b0010, 3'd5, 4'd1, 16'd1234, 32'd1000, 4'b0010, 32'd2000, 1'b1};
        vt[1] = '{4'b0100, 3'd3, 4'd1, 16'd1111, 32'd0,    4'b0100, 32'd0,    1'b0};
        vt[2] = '{4'b1001, 3'd5, 4'd2, 16'd1234, 32'd50,   4'b1000, 32'd0,    1'b0};
        vt[3] = '{4'b0011, 3'd3, 4'd1, 16'd1234, 32'd0,    4'b0001, 32'd1000, 1'b1};
        vt[4] = '{4'b0101, 3'd5, 4'd1, 16'd1234, 32'd7,    4'b0100, 32'd1007, 1'b1};
        vt[5] = '{4'b0001, 3'd0, 4'd1, 16'd1234, 32'd0,    4'b0001, 32'd0,    1'b0};
        v_t1  = '{4'b0010, 3'd3, 4'd1, 16'd1234, 32'd0,    4'b0010, 32'd1000, 1'b1};
        v_t3  = '{4'b1000, 3'd3, 4'd1, 16'd1234, 32'd0,    4'b1000, 32'd1000, 1'b1};
        exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        bus.req = '0;
        for (int t = 0; t < 4; t++) set_term(t, 3'd0, 4'd0, 16'd0, 32'd0);

        // Reset state
        tick(); tick();
        chk("rst.grant", bus.grant, 4'b0);
        chk("rst.done", bus.done, 4'b0);
        chk("rst.aborted", bus.aborted, 4'b0);
        chk("rst.bal", bus.result_balance, 32'd0);
        chk("rst.succ", bus.result_success, 1'b0);
        chk("rst.core_rst", bus.core_rst, 1'b0);
        chk("rst.core_op", bus.core_operation, 3'd0);
        rst = 1'b1;
        tick();
        chk("rel.core_rst", bus.core_rst, 1'b1);
        chk("rel.grant", bus.grant, 4'b0);

        // Single request, exact timing, capture isolation
        set_term(0, 3'd3, 4'd1, 16'd1234, 32'd0);
        bus.t_language[0] = 1'b1;
        bus.t_new_pin[15:0] = 16'd4321;
        bus.req = 4'b0001;
        tick();
        chk("s.grant", bus.grant, 4'b0001);
        chk("s.core_op", bus.core_operation, 3'd3);
        chk("s.core_pin", bus.core_pin, 16'd1234);
        chk("s.core_lang", bus.core_language, 1'b1);
        chk("s.core_npin", bus.core_new_pin, 16'd4321);
        bus.t_pin[15:0] = 16'd9999;
        tick(); tick(); tick();
        chk("s.early_done", bus.done, 4'b0);
        tick();
        chk("s.done", bus.done, 4'b0001);
        chk("s.bal", bus.result_balance, 32'd1000);
        chk("s.succ", bus.result_success, 1'b1);
        chk("s.grant_resp", bus.grant, 4'b0001);
        bus.req = 4'b0;
        tick();
        chk("s.clear_rst", bus.core_rst, 1'b0);
        chk("s.clear_grant", bus.grant, 4'b0);
        chk("s.clear_done", bus.done, 4'b0);
        chk("s.held_pin", bus.core_pin, 16'd1234);
        tick();
        chk("s.idle_rst", bus.core_rst, 1'b1);

        // Table of sessions walking the round-robin pointer
        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Fairness from reset with all requests held
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int t = 0; t < 4; t++) set_term(t, 3'd3, 4'd1, 16'd1234, 32'd0);
        tick();
        rst = 1'b1;
        for (int t = 1; t <= 60 && done_v.size() < 5; t++) begin
            tick();
            if (bus.done != 4'b0) begin
                done_t.push_back(t);
                done_v.push_back(bus.done);
            end
        end
        bus.req = 4'b0;
        chk("fair.count", done_v.size(), 5);
        if (done_t.size() > 0) chk("fair.first_t", done_t[0], 5);
        for (int i = 0; i < 5; i++) begin
            if (i < done_v.size()) chk($sformatf("fair.order%0d", i), done_v[i], exp_ord[i]);
            if (i > 0 && i < done_t.size())
                chk($sformatf("fair.gap%0d", i), done_t[i] - done_t[i-1], 7);
        end
        tick(); tick();

        // Abort: move pointer to 2, then term2 drops req two cycles into RUN
        run_vec(v_t1, "pre_abort");
        set_term(2, 3'd3, 4'd1, 16'd1234, 32'd0);
        bus.req = 4'b0100;
        tick();
        chk("ab.grant", bus.grant, 4'b0100);
        tick();
        bus.req = 4'b0000;
        tick();
        chk("ab.aborted", bus.aborted, 4'b0100);
        chk("ab.done", bus.done, 4'b0);
        chk("ab.grant_clr", bus.grant, 4'b0);
        chk("ab.core_rst", bus.core_rst, 1'b0);
        tick();
        chk("ab.pulse_end", bus.aborted, 4'b0);
        chk("ab.idle_rst", bus.core_rst, 1'b1);
        bus.req = 4'b1100;
        tick();
        chk("ab.regrant", bus.grant, 4'b0100);
        n = 0;
        while (bus.done == 4'b0 && n < 20) begin tick(); n++; end
        chk("ab.redone", bus.done, 4'b0100);
        bus.req = 4'b0;
        tick(); tick();

        // Reset during RUN of term3
        for (int t = 0; t < 4; t++) set_term(t, 3'd3, 4'd1, 16'd1234, 32'd0);
        bus.req = 4'b1000;
        tick();
        chk("mr.grant", bus.grant, 4'b1000);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("mr.grant_rst", bus.grant, 4'b0);
        chk("mr.core_rst", bus.core_rst, 1'b0);
        chk("mr.core_op", bus.core_operation, 3'd0);
        bus.req = 4'b1010;
        tick();
        chk("mr.done_rst", bus.done, 4'b0);
        rst = 1'b1;
        tick();
        chk("mr.ptr0_grant", bus.grant, 4'b0010);
        n = 0;
        while (bus.done == 4'b0 && n < 20) begin tick(); n++; end
        chk("mr.done1", bus.done, 4'b0010);
        bus.req = 4'b0;
        tick(); tick();
        run_vec(v_t3, "post_rst_t3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
